// File: rtl/freq_meter_counter.sv
// ---------------------------------------------------------------------------
// freq_meter_counter
//
// Measurement end of the frequency-meter chain. Counts rising edges of an
// asynchronous input over a fixed gate window of GATE_CYCLES clk cycles and
// latches each completed count as a frequency word. Consecutive windows are
// contiguous while enabled, so there is no dead time between gates.
//
// Parameters:
//   GATE_CYCLES  gate window length in clk cycles (>= 2)
//   CNT_W        width of the edge counter and of the result word
//   SYNC_STAGES  synchronizer flops on sig_in (>= 2)
//
// Ports:
//   clk         system clock, all logic on the rising edge
//   rst_n       asynchronous active-low reset
//   en          measurement enable (synchronous level)
//   sig_in      signal under measurement, asynchronous to clk
//   freq        last completed gate count (saturated at 2^CNT_W-1)
//   freq_valid  one-cycle pulse when freq updates
//   ovf         last completed gate saturated
//   busy        gate window in progress
//   bcd         7-digit BCD of freq (all zero unless BCD_EN is defined)
//
// Optional feature (macro BCD_EN):
//   When defined, each gate result is converted to BCD by a sequential
//   shift-add-3 engine running CNT_W cycles in state CONV while the next
//   window is already counting. freq, ovf and bcd update together, and
//   values above 9999999 show as all nines with ovf set. GATE_CYCLES must
//   exceed CNT_W+1 so a conversion always ends before the next gate does.
// ---------------------------------------------------------------------------
module freq_meter_counter #(
  parameter int GATE_CYCLES = 1000000,
  parameter int CNT_W       = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq,
  output logic             freq_valid,
  output logic             ovf,
  output logic             busy,
  output logic [27:0]      bcd
);

  localparam int               TW         = $clog2(GATE_CYCLES);
  localparam logic [TW-1:0]    TIMER_LAST = TW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

`ifdef BCD_EN
  typedef enum logic [1:0] {IDLE = 2'd0, GATE = 2'd1, CONV = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, GATE = 2'd1} state_t;
`endif

  state_t                 state_q;
  state_t                 next_state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   edge_det;
  logic [TW-1:0]          timer_q;
  logic [CNT_W-1:0]       count_q;
  logic                   sat_q;
  logic                   counting;
  logic                   terminal;
  logic [CNT_W-1:0]       result;
  logic                   result_sat;

  // Synchronizer chain followed by a history flop; a rising edge is seen
  // for exactly one cycle when the synchronized level goes 0 -> 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_det = sync_q[SYNC_STAGES-1] & ~hist_q;

  // The edge arriving on the terminal cycle still belongs to the closing
  // window, so it is folded into the result here rather than into count_q.
  assign result_sat = sat_q | ((count_q == CNT_MAX) & edge_det);
  assign result     = (count_q == CNT_MAX) ? CNT_MAX : count_q + CNT_W'(edge_det);

`ifdef BCD_EN
  localparam int          CCW     = $clog2(CNT_W + 1);
  localparam logic [63:0] BCD_MAX = 64'd9999999;

  logic [CNT_W-1:0] conv_bin_q;
  logic [CNT_W-1:0] conv_res_q;
  logic             conv_ovf_q;
  logic             conv_clamp_q;
  logic [27:0]      conv_bcd_q;
  logic [27:0]      bcd_q;
  logic [27:0]      dd_adj;
  logic [27:0]      dd_next;
  logic [CCW-1:0]   conv_cnt_q;
  logic             conv_last;
  logic             over_disp;

  assign conv_last = (conv_cnt_q == CCW'(CNT_W - 1));
  assign over_disp = 64'(result) > BCD_MAX;
  assign bcd       = bcd_q;

  // One shift-add-3 step: every digit >= 5 gets +3 before the whole BCD
  // word shifts left, pulling in the next binary bit MSB first. Digits
  // beyond the seventh are dropped; such values are clamped to all nines.
  always_comb begin
    dd_adj = conv_bcd_q;
    for (int d = 0; d < 7; d++) begin
      if (conv_bcd_q[4*d +: 4] >= 4'd5) begin
        dd_adj[4*d +: 4] = conv_bcd_q[4*d +: 4] + 4'd3;
      end
    end
    dd_next = {dd_adj[26:0], conv_bin_q[CNT_W-1]};
  end
`else
  assign bcd = '0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= next_state;
    end
  end

  // Next-state and control decode. A window that reaches its terminal
  // cycle always completes, even if en drops in that same cycle; en low
  // on any earlier gate cycle aborts the window without a result.
  always_comb begin
    next_state = state_q;
    busy       = 1'b0;
    counting   = 1'b0;
    terminal   = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          next_state = GATE;
        end
      end
      GATE: begin
        busy     = 1'b1;
        counting = 1'b1;
        if (timer_q == TIMER_LAST) begin
          terminal = 1'b1;
`ifdef BCD_EN
          next_state = CONV;
`else
          next_state = en ? GATE : IDLE;
`endif
        end else if (!en) begin
          next_state = IDLE;
        end
      end
`ifdef BCD_EN
      CONV: begin
        busy     = 1'b1;
        counting = 1'b1;
        if (conv_last) begin
          next_state = en ? GATE : IDLE;
        end
      end
`endif
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Gate timer and edge counter. Both restart on the terminal cycle so the
  // next window begins immediately, and are held clear outside a window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
      count_q <= '0;
      sat_q   <= 1'b0;
    end else if (!counting || terminal) begin
      timer_q <= '0;
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      timer_q <= timer_q + TW'(1);
      if (edge_det) begin
        if (count_q == CNT_MAX) begin
          sat_q <= 1'b1;
        end else begin
          count_q <= count_q + CNT_W'(1);
        end
      end
    end
  end

  // Result registers. Without BCD the result is published straight from
  // the terminal cycle; with BCD it is held until the conversion finishes
  // so that freq, ovf and bcd always change together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freq       <= '0;
      ovf        <= 1'b0;
      freq_valid <= 1'b0;
`ifdef BCD_EN
      conv_bin_q   <= '0;
      conv_res_q   <= '0;
      conv_ovf_q   <= 1'b0;
      conv_clamp_q <= 1'b0;
      conv_bcd_q   <= '0;
      conv_cnt_q   <= '0;
      bcd_q        <= '0;
`endif
    end else begin
      freq_valid <= 1'b0;
`ifdef BCD_EN
      if (terminal) begin
        conv_bin_q   <= result;
        conv_res_q   <= result;
        conv_ovf_q   <= result_sat | over_disp;
        conv_clamp_q <= over_disp;
        conv_bcd_q   <= '0;
        conv_cnt_q   <= '0;
      end else if (state_q == CONV) begin
        conv_bin_q <= conv_bin_q << 1;
        conv_bcd_q <= dd_next;
        conv_cnt_q <= conv_cnt_q + CCW'(1);
        if (conv_last) begin
          freq       <= conv_res_q;
          ovf        <= conv_ovf_q;
          bcd_q      <= conv_clamp_q ? 28'h9999999 : dd_next;
          freq_valid <= 1'b1;
        end
      end
`else
      if (terminal) begin
        freq       <= result;
        ovf        <= result_sat;
        freq_valid <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_freq_meter_counter.sv
// ---------------------------------------------------------------------------
// tb_freq_meter_counter
//
// Self-checking bench for freq_meter_counter in its default build (BCD_EN
// undefined). A behavioural model counts rising transitions of the delayed
// sampled input over whole windows and derives the expected outputs from
// those counts; a compare process checks every output on every falling
// clock edge. Directed phases pin the model with hand-computed values.
// ---------------------------------------------------------------------------
module tb_freq_meter_counter;

  localparam int G    = 1000;
  localparam int W    = 8;
  localparam int S    = 2;
  localparam int MAXC = (1 << W) - 1;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         sig_in;
  logic [W-1:0] freq;
  logic         freq_valid;
  logic         ovf;
  logic         busy;
  logic [27:0]  bcd;

  int checks;
  int passes;
  bit checking;
  bit rand_mode;
  int period;

  int  m_freq;
  bit  m_ovf;
  bit  m_valid;
  bit  m_busy;
  bit  m_active;
  int  m_pos;
  int  m_edges;
  bit  shist [0:S];

  freq_meter_counter #(
    .GATE_CYCLES (G),
    .CNT_W       (W),
    .SYNC_STAGES (S)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .sig_in     (sig_in),
    .freq       (freq),
    .freq_valid (freq_valid),
    .ovf        (ovf),
    .busy       (busy),
    .bcd        (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic waitValid(input string name, input int maxc, output int cycles);
    bit got;
    got    = 1'b0;
    cycles = 0;
    while (!got && cycles < maxc) begin
      @(negedge clk);
      cycles++;
      if (freq_valid) got = 1'b1;
    end
    checkOutput({name, "_seen"}, 32'(got), 32'd1);
  endtask

  task automatic applyStimulus(input bit en_val, input int ncycles);
    en = en_val;
    repeat (ncycles) @(negedge clk);
  endtask

  // Input generator: fixed-period square wave, or random high/low runs of
  // 1..8 cycles each so the period never drops below two clocks.
  initial begin
    int ph;
    int hold;
    ph     = 0;
    hold   = 0;
    sig_in = 1'b0;
    forever begin
      @(negedge clk);
      if (rand_mode) begin
        if (hold == 0) begin
          sig_in = ~sig_in;
          hold   = $urandom_range(1, 8);
        end
        hold--;
      end else begin
        sig_in = ((ph % period) < (period / 2));
        ph++;
      end
    end
  end

  // Reference model: a window opens the cycle after en is seen while idle,
  // spans exactly G cycles, and reports the number of rising transitions of
  // sig_in as seen S+1 samples late, clamped to MAXC.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= S; k++) shist[k] = 1'b0;
      m_active = 1'b0;
      m_pos    = 0;
      m_edges  = 0;
      m_freq   = 0;
      m_ovf    = 1'b0;
      m_valid  = 1'b0;
      m_busy   = 1'b0;
    end else begin
      int e;
      e       = (shist[S-1] && !shist[S]) ? 1 : 0;
      m_valid = 1'b0;
      if (m_active) begin
        m_edges += e;
        m_pos++;
        if (m_pos == G) begin
          m_freq   = (m_edges > MAXC) ? MAXC : m_edges;
          m_ovf    = (m_edges > MAXC);
          m_valid  = 1'b1;
          m_pos    = 0;
          m_edges  = 0;
          m_active = en;
        end else if (!en) begin
          m_active = 1'b0;
        end
      end else if (en) begin
        m_active = 1'b1;
        m_pos    = 0;
        m_edges  = 0;
      end
      m_busy = m_active;
      for (int k = S; k > 0; k--) shist[k] = shist[k-1];
      shist[0] = sig_in;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (checking) begin
      checkOutput("freq", 32'(freq), 32'(m_freq));
      checkOutput("ovf", 32'(ovf), 32'(m_ovf));
      checkOutput("freq_valid", 32'(freq_valid), 32'(m_valid));
      checkOutput("busy", 32'(busy), 32'(m_busy));
      checkOutput("bcd", 32'(bcd), 32'd0);
    end
  end

  initial begin
    int cyc;
    int nvalid;
    checks    = 0;
    passes    = 0;
    checking  = 1'b0;
    rand_mode = 1'b0;
    period    = 2;
    rst_n     = 1'b0;
    en        = 1'b0;
    repeat (3) @(negedge clk);
    checking = 1'b1;
    checkOutput("reset_freq", 32'(freq), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_valid", 32'(freq_valid), 32'd0);
    checkOutput("reset_ovf", 32'(ovf), 32'd0);

    // Maximum rate input saturates the 8-bit counter.
    $display("[TB] period 2, saturation");
    rst_n = 1'b1;
    applyStimulus(1'b1, 1);
    checkOutput("start_busy", 32'(busy), 32'd1);
    waitValid("p2_first", G + 100, cyc);
    checkOutput("p2_freq", 32'(freq), 32'd255);
    checkOutput("p2_ovf", 32'(ovf), 32'd1);
    waitValid("p2_second", G + 100, cyc);
    checkOutput("p2_interval", 32'(cyc), 32'(G));
    checkOutput("p2_freq2", 32'(freq), 32'd255);

    // Divided references; the window spanning each switch is skipped.
    $display("[TB] divided references");
    period = 16;
    waitValid("p16_mixed", G + 100, cyc);
    waitValid("p16", G + 100, cyc);
    checkOutput("p16_freq_62_63", 32'((freq == 8'd62) || (freq == 8'd63)), 32'd1);
    checkOutput("p16_ovf", 32'(ovf), 32'd0);
    period = 4;
    waitValid("p4_mixed", G + 100, cyc);
    waitValid("p4", G + 100, cyc);
    checkOutput("p4_freq", 32'(freq), 32'd250);
    period = 8;
    waitValid("p8_mixed", G + 100, cyc);
    waitValid("p8", G + 100, cyc);
    checkOutput("p8_freq", 32'(freq), 32'd125);

    // Abort half way through a window, then restart.
    $display("[TB] abort and restart");
    applyStimulus(1'b1, 500);
    applyStimulus(1'b0, 1);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_freq", 32'(freq), 32'd125);
    nvalid = 0;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      if (freq_valid) nvalid++;
    end
    checkOutput("abort_no_valid", 32'(nvalid), 32'd0);
    en = 1'b1;
    waitValid("restart", G + 100, cyc);
    checkOutput("restart_latency", 32'(cyc), 32'(G + 1));
    checkOutput("restart_freq", 32'(freq), 32'd125);

    // Random input with random enable drops, checked by the model only.
    $display("[TB] random phase");
    rand_mode = 1'b1;
    for (int r = 0; r < 6; r++) begin
      applyStimulus(1'b1, $urandom_range(1500, 3200));
      applyStimulus(1'b0, $urandom_range(1, 20));
    end

    // Asynchronous reset in the middle of a window.
    $display("[TB] async reset mid-window");
    applyStimulus(1'b1, 1500);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_freq", 32'(freq), 32'd0);
    checkOutput("async_ovf", 32'(ovf), 32'd0);
    checkOutput("async_busy", 32'(busy), 32'd0);
    checkOutput("async_valid", 32'(freq_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rerun_busy", 32'(busy), 32'd1);
    waitValid("rerun", G + 100, cyc);
    checkOutput("rerun_latency", 32'(cyc), 32'(G));
    repeat (5) @(negedge clk);

    checking = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
